segre_fetch_unit: RTL and testbench

Parametrised successor fetch stage: owns the PC and issues word fetches to the instruction cache over a req/gnt/rvalid handshake. Buffers returned instructions in an FQ_DEPTH-entry fetch queue feeding decode via valid/ready. Supports taken-branch redirect with queue flush and squash of an in-flight stale response. Sits between the I-cache and the ID stage; replaces the single-register IF stage.

---
 rtl/segre_pkg.sv | 21 ++
 rtl/segre_fetch_queue.sv | 58 +++++
 rtl/segre_fetch_unit.sv | 122 ++++++++++++
 tb/tb_segre_fetch_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and defaults for the segre core.
// Fetch stage state and fetch queue entry layout.
package segre_pkg;

  localparam int unsigned DEF_ADDR_SIZE = 32;
  localparam int unsigned DEF_WORD_SIZE = 32;
  localparam int unsigned DEF_FQ_DEPTH  = 4;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RESP,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [DEF_ADDR_SIZE-1:0] pc;
    logic [DEF_WORD_SIZE-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/segre_fetch_queue.sv
// Circular fetch queue between the fetch FSM and decode.
// Flush clears pointers and count; storage is not reset.
module segre_fetch_queue
  import segre_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FQ_DEPTH,
  parameter type entry_t = fq_entry_t,
  parameter int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push)
      mem[wr_ptr] <= push_data;
  end

  // issue gating upstream must make this unreachable
  always_ff @(posedge clk) begin
    if (!rst && !flush)
      assert (!(push && full && !pop))
        else $error("fetch queue overflow");
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/segre_fetch_unit.sv
// Fetch stage: owns the PC, issues I-cache requests and
// buffers responses in a fetch queue feeding decode.
module segre_fetch_unit
  import segre_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int unsigned WORD_SIZE = DEF_WORD_SIZE,
  parameter int unsigned FQ_DEPTH  = DEF_FQ_DEPTH,
  parameter logic [ADDR_SIZE-1:0] RESET_PC =
    ADDR_SIZE'(DEF_RESET_PC)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         ic_req_o,
  output logic [ADDR_SIZE-1:0]         ic_addr_o,
  input  logic                         ic_gnt_i,
  input  logic                         ic_rvalid_i,
  input  logic [WORD_SIZE-1:0]         ic_rdata_i,
  input  logic                         redirect_i,
  input  logic [ADDR_SIZE-1:0]         redirect_pc_i,
  output logic                         id_valid_o,
  input  logic                         id_ready_i,
  output logic [WORD_SIZE-1:0]         id_instr_o,
  output logic [ADDR_SIZE-1:0]         id_pc_o,
  output logic [$clog2(FQ_DEPTH):0]    fq_count_o
);

  localparam int unsigned CW = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } entry_t;

  fetch_state_e state_q, state_d;
  logic [ADDR_SIZE-1:0] pc_q, pc_d;
  logic [ADDR_SIZE-1:0] req_pc_q, req_pc_d;
  logic req, push, pop;
  logic fq_full, fq_empty;
  logic [CW-1:0] count;
  entry_t head, push_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req      = 1'b0;
    push     = 1'b0;
    if (redirect_i) begin
      pc_d = redirect_pc_i & ~ADDR_SIZE'(3);
      // a response still owed by the cache must be swallowed
      unique case (state_q)
        IDLE:      state_d = IDLE;
        WAIT_RESP: state_d = ic_rvalid_i ? IDLE : DROP;
        DROP:      state_d = ic_rvalid_i ? IDLE : DROP;
        default:   state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          req = !fq_full;
          if (req && ic_gnt_i) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_SIZE'(4);
            state_d  = WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (ic_rvalid_i) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (ic_rvalid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign push_data.pc    = req_pc_q;
  assign push_data.instr = ic_rdata_i;

  segre_fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t),
    .CW      (CW)
  ) u_fq (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (fq_full),
    .empty     (fq_empty)
  );

  assign ic_req_o   = req && !rst_i;
  assign ic_addr_o  = rst_i ? RESET_PC : pc_q;
  assign id_valid_o = !fq_empty && !redirect_i && !rst_i;
  assign pop        = id_valid_o && id_ready_i;
  assign id_instr_o = rst_i ? '0 : head.instr;
  assign id_pc_o    = rst_i ? '0 : head.pc;
  assign fq_count_o = rst_i ? '0 : count;

endmodule

// File: tb/tb_segre_fetch_unit.sv
// Self-checking bench for segre_fetch_unit with a
// queue-based reference model and a simple I-cache responder.
module tb_segre_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst_i;
  logic        ic_req_o;
  logic [31:0] ic_addr_o;
  logic        ic_gnt_i;
  logic        ic_rvalid_i;
  logic [31:0] ic_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [2:0]  fq_count_o;
  logic        gnt_en;

  int tests = 0;
  int fails = 0;

  // knobs applied at the next negedge
  bit          k_rst, k_redirect, k_ready;
  logic [31:0] k_rpc;
  bit          gnt_allow, spur;
  int          delay;
  bit          force_valid;
  logic [31:0] force_data;

  // reference model
  ent_t        m_q[$];
  logic [31:0] m_pc, m_req_pc;
  bit          m_wait, m_drop;

  // cache responder
  bit          c_pending;
  int          c_delay;
  logic [31:0] c_addr;

  logic [31:0] obs_pcs[$];
  logic        obs_req;
  logic [31:0] obs_addr;
  logic [2:0]  obs_count;

  assign ic_gnt_i = ic_req_o & gnt_en;

  segre_fetch_unit dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .ic_req_o      (ic_req_o),
    .ic_addr_o     (ic_addr_o),
    .ic_gnt_i      (ic_gnt_i),
    .ic_rvalid_i   (ic_rvalid_i),
    .ic_rdata_i    (ic_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .fq_count_o    (fq_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memw(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ok(string tag, bit cond);
    tests++;
    assert (cond) else begin
      fails++;
      $error("FAIL %s observed=0 expected=1", tag);
    end
  endtask

  task automatic step();
    bit deliver;
    bit exp_req, exp_valid;
    @(negedge clk);
    rst_i         = k_rst;
    redirect_i    = k_redirect;
    redirect_pc_i = k_rpc;
    id_ready_i    = k_ready;
    gnt_en        = gnt_allow && !c_pending;
    deliver       = 0;
    ic_rvalid_i   = 1'b0;
    ic_rdata_i    = $urandom;
    if (c_pending) begin
      c_delay--;
      if (c_delay == 0) begin
        deliver     = 1;
        ic_rvalid_i = 1'b1;
        ic_rdata_i  = force_valid ? force_data : memw(c_addr);
        force_valid = 0;
      end
    end else if (spur && $urandom_range(7) == 0) begin
      ic_rvalid_i = 1'b1;
    end
    #1;
    obs_req   = ic_req_o;
    obs_addr  = ic_addr_o;
    obs_count = fq_count_o;
    exp_req   = 0;
    exp_valid = 0;
    if (k_rst) begin
      chk("rst_req", 32'(ic_req_o), 32'd0);
      chk("rst_valid", 32'(id_valid_o), 32'd0);
      chk("rst_addr", ic_addr_o, 32'h0);
      chk("rst_instr", id_instr_o, 32'h0);
      chk("rst_pc", id_pc_o, 32'h0);
      chk("rst_count", 32'(fq_count_o), 32'd0);
    end else begin
      exp_req = !k_redirect && !m_wait && !m_drop
                && m_q.size() < DEPTH;
      exp_valid = !k_redirect && m_q.size() != 0;
      chk("req", 32'(ic_req_o), 32'(exp_req));
      chk("valid", 32'(id_valid_o), 32'(exp_valid));
      chk("count", 32'(fq_count_o), 32'(m_q.size()));
      if (exp_req) chk("addr", ic_addr_o, m_pc);
      if (exp_valid) begin
        chk("id_pc", id_pc_o, m_q[0].pc);
        chk("id_instr", id_instr_o, m_q[0].instr);
      end
    end
    if (!k_rst && id_valid_o && id_ready_i)
      obs_pcs.push_back(id_pc_o);
    if (k_rst) begin
      m_q.delete();
      m_pc   = 32'h0;
      m_wait = 0;
      m_drop = 0;
    end else if (k_redirect) begin
      m_q.delete();
      m_pc = k_rpc & 32'hFFFF_FFFC;
      if (m_wait || m_drop) begin
        m_drop = !ic_rvalid_i;
        m_wait = 0;
      end
    end else begin
      if (exp_valid && k_ready) void'(m_q.pop_front());
      if (ic_rvalid_i && m_wait) begin
        m_q.push_back('{pc: m_req_pc, instr: ic_rdata_i});
        m_wait = 0;
      end else if (ic_rvalid_i && m_drop) begin
        m_drop = 0;
      end
      if (exp_req && gnt_en) begin
        m_req_pc = m_pc;
        m_wait   = 1;
        c_pending = 1;
        c_addr    = m_pc;
        c_delay   = delay;
        m_pc      = m_pc + 32'd4;
      end
    end
    if (deliver) c_pending = 0;
  endtask

  initial begin
    int n;
    rst_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
    id_ready_i = 1'b0; ic_rvalid_i = 1'b0; ic_rdata_i = '0;
    gnt_en = 1'b0;
    k_rst = 1; k_redirect = 0; k_ready = 1; k_rpc = '0;
    gnt_allow = 1; spur = 0; delay = 1; force_valid = 0;
    force_data = '0;
    m_pc = '0; m_req_pc = '0; m_wait = 0; m_drop = 0;
    c_pending = 0; c_delay = 0; c_addr = '0;

    // reset, then streaming fetch with decode always ready
    repeat (2) step();
    k_rst = 0;
    step();
    chk("first_addr", obs_addr, 32'h0);
    chk("first_req", 32'(obs_req), 32'd1);
    repeat (12) step();
    ok("stream_pops", obs_pcs.size() >= 3);
    if (obs_pcs.size() >= 3) begin
      chk("seq0", obs_pcs[0], 32'h0);
      chk("seq1", obs_pcs[1], 32'h4);
      chk("seq2", obs_pcs[2], 32'h8);
    end

    // back-pressure: queue saturates, then one pop
    k_ready = 0;
    repeat (20) step();
    chk("sat_count", 32'(obs_count), 32'd4);
    chk("sat_req", 32'(obs_req), 32'd0);
    k_ready = 1;
    step();
    k_ready = 0;
    step();
    chk("after_pop_count", 32'(obs_count), 32'd3);
    chk("after_pop_req", 32'(obs_req), 32'd1);

    // redirect while waiting, stale response one cycle later
    k_ready = 1;
    delay = 2;
    for (int i = 0; i < 50; i++) begin
      if (m_wait && c_pending && c_delay == 2) break;
      step();
    end
    ok("wait_for_issue_c", m_wait && c_pending && c_delay == 2);
    force_valid = 1;
    force_data  = 32'hDEAD_BEEF;
    k_redirect = 1; k_rpc = 32'h100;
    step();
    k_redirect = 0;
    step();
    chk("drop_count", 32'(obs_count), 32'd0);
    step();
    chk("redir_req", 32'(obs_req), 32'd1);
    chk("redir_addr", obs_addr, 32'h100);
    n = obs_pcs.size();
    for (int i = 0; i < 20; i++) begin
      if (obs_pcs.size() > n) break;
      step();
    end
    ok("redir_pop", obs_pcs.size() > n);
    if (obs_pcs.size() > n) chk("redir_pc", obs_pcs[n], 32'h100);

    // redirect coincident with rvalid and non-empty queue
    k_ready = 0;
    delay = 1;
    for (int i = 0; i < 50; i++) begin
      if (m_q.size() > 0 && m_wait && c_pending && c_delay == 1) break;
      step();
    end
    ok("wait_for_issue_d",
       m_q.size() > 0 && m_wait && c_pending && c_delay == 1);
    k_redirect = 1; k_rpc = 32'h203;
    step();
    k_redirect = 0;
    step();
    chk("flush_count", 32'(obs_count), 32'd0);
    chk("flush_req", 32'(obs_req), 32'd1);
    chk("flush_addr", obs_addr, 32'h200);

    // push and pop in the same cycle at count 2
    for (int i = 0; i < 50; i++) begin
      if (m_q.size() == 2 && m_wait && c_pending && c_delay == 1) break;
      step();
    end
    ok("wait_for_two", m_q.size() == 2 && m_wait && c_delay == 1);
    k_ready = 1;
    step();
    k_ready = 0;
    step();
    chk("pushpop_count", 32'(obs_count), 32'd2);

    // randomized traffic
    spur = 1;
    for (int i = 0; i < 600; i++) begin
      k_ready    = bit'($urandom_range(1));
      gnt_allow  = ($urandom_range(3) != 0);
      delay      = $urandom_range(3, 1);
      k_redirect = ($urandom_range(19) == 0);
      k_rpc      = $urandom;
      if ($urandom_range(3) == 0) k_rpc[31:4] = '1;
      step();
    end
    k_redirect = 0;
    spur = 0;

    // reset while a request is outstanding
    gnt_allow = 1;
    k_ready = 1;
    delay = 3;
    for (int i = 0; i < 50; i++) begin
      if (m_wait && c_pending && c_delay == 3) break;
      step();
    end
    ok("wait_for_issue_g", m_wait && c_pending && c_delay == 3);
    k_rst = 1;
    repeat (2) step();
    k_rst = 0;
    step();
    chk("post_rst_addr", obs_addr, 32'h0);
    chk("post_rst_count", 32'(obs_count), 32'd0);
    delay = 1;
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
